// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult
// Description : Sequential radix-2 shift-add multiplier with signed/unsigned
//               mode and a fixed latency of WIDTH cycles.
//
//               The operand magnitudes are multiplied unsigned. The result
//               is then negated over the full 2*WIDTH bits when the operand
//               signs differ in signed mode.
//
// Ports       : clk        - single clock, rising edge
//               rst_n      - asynchronous active-low reset
//               start      - begin a multiply (sampled only in IDLE)
//               is_signed  - 1 = two's-complement operands, 0 = unsigned
//               A, B       - multiplicand / multiplier (sampled with start)
//               busy       - high while the multiply is running
//               done       - one-cycle pulse, result valid
//               mult_low   - product bits [WIDTH-1:0]
//               mult_high  - product bits [2*WIDTH-1:WIDTH]
//
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mult_low,
    output logic [WIDTH-1:0] mult_high
);

    localparam int              CW       = $clog2(WIDTH);
    // The accept edge already performs step 0, so the last RUN edge is the
    // one where the counter moves from WIDTH-2 to WIDTH-1.
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 2);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               neg_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   low_q;
    logic [WIDTH-1:0]   high_q;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               res_neg;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   step_mcand;
    logic               step_bit;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_d;

    always_comb begin
        // Negating the most negative value yields the same bit pattern,
        // which read as unsigned is exactly 2^(WIDTH-1).
        mag_a   = (is_signed && A[WIDTH-1]) ? -A : A;
        mag_b   = (is_signed && B[WIDTH-1]) ? -B : B;
        res_neg = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);

        // One shared shift-add datapath. In IDLE it is fed a cleared
        // accumulator and the fresh operands, so the accept edge loads the
        // accumulator with "cleared, then step 0 applied".
        if (state_q == S_IDLE) begin
            step_acc   = '0;
            step_mcand = mag_a;
            step_bit   = mag_b[0];
        end else begin
            step_acc   = acc_q;
            step_mcand = mcand_q;
            step_bit   = mplier_q[0];
        end

        step_sum = {1'b0, step_acc[2*WIDTH-1:WIDTH]}
                 + (step_bit ? {1'b0, step_mcand} : {(WIDTH+1){1'b0}});
        acc_d    = {step_sum, step_acc[WIDTH-1:1]};
        prod_d   = neg_q ? -acc_d : acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            low_q    <= '0;
            high_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        mcand_q  <= mag_a;
                        // Bit 0 is consumed on this edge.
                        mplier_q <= mag_b >> 1;
                        neg_q    <= res_neg;
                        acc_q    <= acc_d;
                        cnt_q    <= '0;
                    end
                end
                S_RUN: begin
                    acc_q    <= acc_d;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        low_q   <= prod_d[WIDTH-1:0];
                        high_q  <= prod_d[2*WIDTH-1:WIDTH];
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mult_low  = low_q;
    assign mult_high = high_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult
// Description : Self-checking bench for seq_mult at WIDTH=64 and WIDTH=8.
//               A timeline model per instance predicts busy/done/product
//               every cycle; directed tasks pin literal products and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        s64, sg64;
    logic [63:0] a64, b64;
    logic        busy64, done64;
    logic [63:0] lo64, hi64;

    logic        s8, sg8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [7:0]  lo8, hi8;

    int checks = 0;
    int errors = 0;

    seq_mult #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .start(s64), .is_signed(sg64),
        .A(a64), .B(b64), .busy(busy64), .done(done64),
        .mult_low(lo64), .mult_high(hi64)
    );

    seq_mult #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .is_signed(sg8),
        .A(a8), .B(b8), .busy(busy8), .done(done8),
        .mult_low(lo8), .mult_high(hi8)
    );

    // Exact 2*w-bit product by plain wide arithmetic.
    function automatic logic [127:0] ref_prod(input logic [63:0] a, input logic [63:0] b,
                                              input logic s, input int w);
        logic [127:0] ea, eb, m1, m2;
        m1 = (128'd1 << w) - 128'd1;
        m2 = (128'd1 << (2 * w)) - 128'd1;
        ea = {64'd0, a} & m1;
        eb = {64'd0, b} & m1;
        if (s && ea[w-1]) ea = ea | ~m1;
        if (s && eb[w-1]) eb = eb | ~m1;
        return (ea * eb) & m2;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timeline model: rem counts cycles left of an operation (0 = idle).
    // done is the cycle with rem==1, busy the cycles with rem>=2.
    int           rem64, rem8;
    logic [127:0] pend64, exp64, pend8, exp8;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem64 <= 0;
            exp64 <= '0;
        end else if (rem64 == 0) begin
            if (s64 === 1'b1) begin
                rem64  <= 64;
                pend64 <= ref_prod(a64, b64, sg64, 64);
            end
        end else begin
            rem64 <= rem64 - 1;
            if (rem64 == 2) exp64 <= pend64;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem8 <= 0;
            exp8 <= '0;
        end else if (rem8 == 0) begin
            if (s8 === 1'b1) begin
                rem8  <= 8;
                pend8 <= ref_prod({56'd0, a8}, {56'd0, b8}, sg8, 8);
            end
        end else begin
            rem8 <= rem8 - 1;
            if (rem8 == 2) exp8 <= pend8;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("busy64", busy64, rem64 >= 2);
            check("done64", done64, rem64 == 1);
            check("lo64",   lo64,   exp64[63:0]);
            check("hi64",   hi64,   exp64[127:64]);
            check("busy8",  busy8,  rem8 >= 2);
            check("done8",  done8,  rem8 == 1);
            check("lo8",    lo8,    exp8[7:0]);
            check("hi8",    hi8,    exp8[15:8]);
        end
    end

    task automatic op64(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [63:0] eh, input logic [63:0] el, input string name);
        int lat;
        @(posedge clk); #2;
        s64 = 1'b1; a64 = a; b64 = b; sg64 = s;
        @(posedge clk); #2;
        s64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; sg64 = ~s;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done64 !== 1'b1 && lat < 200);
        check({name, "_lat"}, lat, 64);
        check({name, "_hi"},  hi64, eh);
        check({name, "_lo"},  lo64, el);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] eh, input logic [7:0] el, input string name);
        int lat;
        @(posedge clk); #2;
        s8 = 1'b1; a8 = a; b8 = b; sg8 = s;
        @(posedge clk); #2;
        s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = ~s;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done8 !== 1'b1 && lat < 50);
        check({name, "_lat"}, lat, 8);
        check({name, "_hi"},  hi8, eh);
        check({name, "_lo"},  lo8, el);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0]  ra, rb;
        logic         rs;
        logic [127:0] p;
        int           pulses, first_k, last_k, idle_cnt;

        rst_n = 1'b0;
        s64 = 1'b0; sg64 = 1'b0; a64 = '0; b64 = '0;
        s8  = 1'b0; sg8  = 1'b0; a8  = '0; b8  = '0;

        repeat (2) @(negedge clk);
        check("rst_busy64", busy64, 1'b0);
        check("rst_done64", done64, 1'b0);
        check("rst_lo64",   lo64,   64'd0);
        check("rst_hi64",   hi64,   64'd0);
        check("rst_busy8",  busy8,  1'b0);
        check("rst_lo8",    lo8,    8'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Directed WIDTH=64
        op64(64'hDEADBEEFDECAFBAD, 64'd2, 1'b0, 64'h1, 64'hBD5B7DDFBD95F75A, "u64_dead");
        op64(-64'sd3, 64'd5, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF1, "s64_m3x5");
        op64(-64'sd3, 64'd5, 1'b0, 64'h4, 64'hFFFFFFFFFFFFFFF1, "u64_m3x5");
        op64(64'h8000000000000000, 64'h8000000000000000, 1'b1,
             64'h4000000000000000, 64'h0, "s64_min");
        op64(64'd0, 64'h123456789, 1'b0, 64'h0, 64'h0, "u64_zero");

        // Directed WIDTH=8
        op8(8'h80, 8'h80, 1'b1, 8'h40, 8'h00, "s8_min");
        op8(8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01, "u8_ff");
        op8(8'hFF, 8'hFF, 1'b1, 8'h00, 8'h01, "s8_m1");
        op8(8'h80, 8'h7F, 1'b1, 8'hC0, 8'h80, "s8_minmax");
        op8(8'h7F, 8'h7F, 1'b0, 8'h3F, 8'h01, "u8_7f");
        op8(8'h00, 8'hFF, 1'b1, 8'h00, 8'h00, "s8_zero");

        // Start held high; operands and mode churn every cycle.
        @(posedge clk); #2;
        s8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
        @(posedge clk);
        pulses = 0; first_k = 0; last_k = 0; idle_cnt = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (busy8 !== 1'b1) idle_cnt++;
            if (done8 === 1'b1) begin
                if (pulses == 0) first_k = k;
                else check("hold_period", k - last_k, 9);
                last_k = k;
                pulses++;
            end
            #2;
            a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
            if (k == 45) s8 = 1'b0;
        end
        check("hold_first", first_k, 8);
        check("hold_pulses", pulses, 5);
        check("hold_idle", idle_cnt, 10);

        // Reset in the middle of RUN
        @(posedge clk); #2;
        s8 = 1'b1; a8 = 8'h55; b8 = 8'h33; sg8 = 1'b0;
        @(posedge clk); #2;
        s8 = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy8", busy8, 1'b0);
        check("mid_rst_done8", done8, 1'b0);
        check("mid_rst_lo8",   lo8,   8'd0);
        check("mid_rst_hi8",   hi8,   8'd0);
        check("mid_rst_lo64",  lo64,  64'd0);
        check("mid_rst_hi64",  hi64,  64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        op8(8'd7, 8'd6, 1'b0, 8'd0, 8'd42, "u8_7x6");

        // Random operand/mode pairs
        for (int i = 0; i < 300; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom);
            p  = ref_prod(ra, rb, rs, 64);
            op64(ra, rb, rs, p[127:64], p[63:0], "rnd64");
        end
        for (int i = 0; i < 2000; i++) begin
            ra = {56'd0, 8'($urandom)};
            rb = {56'd0, 8'($urandom)};
            rs = 1'($urandom);
            p  = ref_prod(ra, rb, rs, 8);
            op8(ra[7:0], rb[7:0], rs, p[15:8], p[7:0], "rnd8");
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
